// File: rtl/alu_exec_stage.sv
// Execute stage: decodes the 4-bit ALU function code, computes result and flags,
// and queues them in a 2-entry output FIFO so the MEM stage can stall freely.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_func,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [ERRW-1:0]  err_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAGW-1:0]  tag;
        logic             zero;
        logic             ovf;
        logic             illegal;
    } entry_t;

    function automatic entry_t alu_compute(input logic [3:0]              func,
                                           input logic signed [WIDTH-1:0] a,
                                           input logic signed [WIDTH-1:0] b,
                                           input logic [TAGW-1:0]         tag);
        entry_t                  e;
        logic signed [WIDTH-1:0] r;
        e = '0;
        r = '0;
        // X/Z codes match no item and fall into the illegal default
        case (func)
            4'b0100: begin
                r     = a + b;
                e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b1100: begin
                r     = a - b;
                e.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a ^ b;
            4'b0011: r = ~(a ^ b);
            4'b1101: r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: e.illegal = 1'b1;
        endcase
        e.result = r;
        e.tag    = tag;
        e.zero   = (r == '0);
        return e;
    endfunction

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction

    entry_t          mem_q [2];
    entry_t          alu_res;
    entry_t          head;
    logic [1:0]      count_q, count_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            push, pop;

    assign alu_res   = alu_compute(in_func, $signed(in_a), $signed(in_b), in_tag);
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
            if (alu_res.illegal) begin
                err_d = sat_inc(err_q);
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            err_q    <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
        end
    end

    // Payload storage is not reset; outputs are masked to zero while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= alu_res;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_result  = out_valid ? head.result  : '0;
    assign out_tag     = out_valid ? head.tag     : '0;
    assign out_zero    = out_valid ? head.zero    : 1'b0;
    assign out_ovf     = out_valid ? head.ovf     : 1'b0;
    assign out_illegal = out_valid ? head.illegal : 1'b0;
    assign err_count   = err_q;

endmodule
